// File: rtl/key_req_pkg.sv
// Shared types for the key request driver: key width, key type and FSM state encoding.
package key_req_pkg;
  localparam int KEY_W = 4;

  typedef logic [KEY_W-1:0] key_t;

  typedef enum logic [1:0] {IDLE, REQ, GAP} drv_state_t;
endpackage

// File: rtl/key_fifo.sv
// Small circular FIFO holding keys waiting to be requested; head is the oldest entry, no bypass.
module key_fifo
  import key_req_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  key_t            push_key,
  input  logic            pop,
  output key_t            head,
  output logic            full,
  output logic            empty,
  output logic [CNTW-1:0] count
);

  key_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_key;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNTW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/key_req_driver.sv
// Presents queued keys one at a time on req/req_key until ack or timeout, reports each
// finished key on the done interface, and keeps req low for GAP cycles between requests.
module key_req_driver
  import key_req_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 20,
  parameter int GAP     = 1,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  key_t          in_key,
  output logic          req,
  output key_t          req_key,
  input  logic          ack,
  output logic          done_valid,
  output key_t          done_key,
  output logic [CW-1:0] done_cycles,
  output logic          done_err
);

  localparam int GW   = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  drv_state_t      state;
  logic [CW-1:0]   wait_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNTW-1:0] fifo_count;
  logic            timed_out;
  logic            finish;

  assign in_ready  = !fifo_full;
  assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));
  // Ack is checked before timeout, so an ack on the last allowed cycle still counts.
  assign finish    = (state == REQ) && !fifo_empty && (ack || timed_out);

  key_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid && in_ready),
    .push_key (in_key),
    .pop      (finish),
    .head     (req_key),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req         <= 1'b0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      done_valid  <= 1'b0;
      done_key    <= '0;
      done_cycles <= '0;
      done_err    <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_count != '0) begin
            state    <= REQ;
            req      <= 1'b1;
            wait_cnt <= '0;
          end
        end
        REQ: begin
          if (finish) begin
            req         <= 1'b0;
            done_valid  <= 1'b1;
            done_key    <= req_key;
            done_cycles <= wait_cnt;
            done_err    <= !ack;
            if (GAP > 0) begin
              state   <= key_req_pkg::GAP;
              gap_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        key_req_pkg::GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GW'(GAP - 1)) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule
